// File: rtl/rs485_addr_receiver.sv
// rs485_addr_receiver: 11-bit RS485 address/data frame receiver.
// Frame: start(0), 8 data bits LSB first, flag (1 = address, 0 = data), stop(1).
// An address frame selects or deselects this node; data frames are delivered
// only while selected. A stop-bit error raises frame_err and parks the receiver
// in BREAK until the line returns high.
module rs485_addr_receiver #(
  parameter logic [7:0] SLAVE_ADDR   = 8'h01,
  parameter logic [7:0] BCAST_ADDR   = 8'hFF,
  parameter int         CLKS_PER_BIT = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx,
  output logic       addr_match,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  // Counter only ever has to hold CLKS_PER_BIT-1.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_FLAG,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_sync1;
  logic             r_rxs;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_flag;
  logic             r_selected;
  logic             w_bit_done;
  logic             w_half_done;
  logic             w_stop_sample;
  logic             w_cnt_clr;

  assign w_bit_done    = (r_cnt == CNT_LAST);
  assign w_half_done   = (r_cnt == CNT_HALF);
  assign w_stop_sample = (r_state == ST_STOP) && w_bit_done;
  assign w_cnt_clr     = (w_state_next != r_state) || w_bit_done ||
                         (r_state == ST_IDLE) || (r_state == ST_BREAK);

  // Two-flop synchronizer for the asynchronous Rx line.
  // NOTE: both flops reset to 1 (line idle level) so reset release never
  // looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make r_rxs see the old r_sync1,
      // giving a true two-stage pipeline.
      r_sync1 <= Rx;
      r_rxs   <= r_sync1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns w_state_next (no latch).
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (!r_rxs) w_state_next = ST_START;
      ST_START: if (w_half_done) w_state_next = r_rxs ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_bit_done && (r_bit_idx == 3'd7)) w_state_next = ST_FLAG;
      ST_FLAG:  if (w_bit_done) w_state_next = ST_STOP;
      ST_STOP:  if (w_bit_done) w_state_next = r_rxs ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (r_rxs) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Bit-timing counter: cleared on every state change and at each bit end.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_cnt <= '0;
    else if (w_cnt_clr) r_cnt <= '0;
    else                r_cnt <= r_cnt + 1'b1;
  end

  // Mid-bit sampling of data bits (LSB first) and the flag bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_flag    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_bit_idx <= 3'd0;
      if ((r_state == ST_DATA) && w_bit_done) begin
        r_shift   <= {r_rxs, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if ((r_state == ST_FLAG) && w_bit_done) r_flag <= r_rxs;
    end
  end

  // Frame evaluation at the stop sample; all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_match <= 1'b0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      rx_data    <= 8'h00;
      r_selected <= 1'b0;
    end else begin
      addr_match <= 1'b0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= (w_state_next != ST_IDLE);
      if (w_stop_sample) begin
        if (!r_rxs) begin
          frame_err  <= 1'b1;
          r_selected <= 1'b0;
        end else if (r_flag) begin
          // Own-address match is checked first so it wins if both addresses are equal.
          if (r_shift == SLAVE_ADDR) begin
            addr_match <= 1'b1;
            r_selected <= 1'b1;
          end else if (r_shift == BCAST_ADDR) begin
            r_selected <= 1'b1;
          end else begin
            r_selected <= 1'b0;
          end
        end else if (r_selected) begin
          rx_data  <= r_shift;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs485_addr_receiver.sv
// Testbench for rs485_addr_receiver: frame-level model predicts which pulse
// each sent frame must produce and when; one compare process checks every cycle.
module tb_rs485_addr_receiver;

  localparam int CPB = 50;
  localparam logic [7:0] SLAVE = 8'h01;
  localparam logic [7:0] BCAST = 8'hFF;
  // Stop sample lands 2 (sync) + CPB/2 + 10*CPB clocks after the falling edge.
  localparam int LAT = 2 + CPB / 2 + 10 * CPB;

  localparam int K_AM = 0;
  localparam int K_RV = 1;
  localparam int K_FE = 2;

  typedef struct {
    int         exp;
    int         kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       addr_match;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_fail = 0;
  bit         started = 1'b0;
  exp_t       q[$];
  logic [7:0] m_data = 8'h00;
  bit         m_sel = 1'b0;
  int         n_am = 0;
  int         n_rv = 0;
  int         n_fe = 0;
  int         last_am_cyc = 0;
  int         last_start = 0;

  rs485_addr_receiver #(
    .SLAVE_ADDR  (SLAVE),
    .BCAST_ADDR  (BCAST),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .Rx        (rx_line),
    .addr_match(addr_match),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: what a complete frame must produce, from the protocol rules.
  task automatic model_frame(input logic [7:0] b, input logic flag, input logic stop, input int c0);
    exp_t e;
    e.exp  = c0 + LAT;
    e.data = b;
    e.kind = -1;
    if (!stop) begin
      e.kind = K_FE;
      m_sel  = 1'b0;
    end else if (flag) begin
      if (b == SLAVE) begin
        e.kind = K_AM;
        m_sel  = 1'b1;
      end else begin
        m_sel = (b == BCAST);
      end
    end else if (m_sel) begin
      e.kind = K_RV;
    end
    if (e.kind >= 0) q.push_back(e);
  endtask

  // Drive one frame; cut > 0 abandons it after that many clocks with Rx high.
  task automatic send_frame(input logic [7:0] b, input logic flag, input logic stop, input int cut);
    logic [10:0] bits;
    int k;
    bits = {stop, flag, b, 1'b0};
    k = 0;
    @(negedge clk);
    last_start = cyc;
    if (cut == 0) model_frame(b, flag, stop, cyc);
    for (int i = 0; i < 11; i++) begin
      rx_line = bits[i];
      for (int j = 0; j < CPB; j++) begin
        if (i != 0 || j != 0) @(negedge clk);
        k++;
        if (cut > 0 && k >= cut) begin
          rx_line = 1'b1;
          return;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Compare process: pulses against the model queue, rx_data against model data.
  always @(negedge clk) begin
    if (started && rst_n) begin
      check("pulse_onehot", 32'(addr_match + rx_valid + frame_err > 1), 0);
      if (addr_match || rx_valid || frame_err) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", {29'd0, addr_match, rx_valid, frame_err}, 0);
        end else begin
          check("pulse_kind", addr_match ? K_AM : (rx_valid ? K_RV : K_FE), q[0].kind);
          check("pulse_time_window", 32'((cyc >= q[0].exp - 1) && (cyc <= q[0].exp + 1)), 1);
          if (rx_valid) m_data = q[0].data;
          void'(q.pop_front());
        end
        if (addr_match) begin
          n_am++;
          last_am_cyc = cyc;
        end
        if (rx_valid) n_rv++;
        if (frame_err) n_fe++;
      end else if (q.size() > 0 && cyc > q[0].exp + 1) begin
        check("missing_pulse", {29'd0, addr_match, rx_valid, frame_err},
              (q[0].kind == K_AM) ? 4 : (q[0].kind == K_RV) ? 2 : 1);
        void'(q.pop_front());
      end
      check("rx_data", rx_data, m_data);
    end
  end

  initial begin
    int busy_cnt;
    int am0, rv0, fe0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_addr_match", addr_match, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    started = 1'b1;
    idle(10);

    // Own address: one addr_match at the specified latency.
    am0 = n_am;
    send_frame(8'h01, 1'b1, 1'b1, 0);
    idle(20);
    check("t1_am_count", n_am - am0, 1);
    check("t1_latency_527pm1", 32'((last_am_cyc - last_start >= 526) && (last_am_cyc - last_start <= 528)), 1);
    check("t1_no_rv", n_rv, 0);
    check("t1_no_fe", n_fe, 0);

    // Foreign address deselects; data discarded.
    send_frame(8'h05, 1'b1, 1'b1, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    idle(20);
    check("t2_no_rv", n_rv, 0);
    check("t2_rx_data", rx_data, 8'h00);

    // Select, then two back-to-back data frames.
    rv0 = n_rv;
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    idle(20);
    check("t3_rv_count", n_rv - rv0, 2);
    check("t3_rx_data", rx_data, 8'h3C);

    // Broadcast selects without addr_match.
    am0 = n_am;
    send_frame(8'hFF, 1'b1, 1'b1, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    idle(20);
    check("bc_no_am", n_am - am0, 0);
    check("bc_rx_data", rx_data, 8'h5A);

    // Short low glitch: back to IDLE, busy brief.
    busy_cnt = 0;
    @(negedge clk);
    rx_line = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 10) rx_line = 1'b1;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("glitch_busy_short", 32'((busy_cnt > 0) && (busy_cnt < 30)), 1);
    check("glitch_idle", busy, 0);

    // Stop-bit error with line held low, then a data frame gets no rx_valid.
    fe0 = n_fe;
    am0 = n_am;
    rv0 = n_rv;
    send_frame(8'h01, 1'b1, 1'b0, 0);
    repeat (200) @(negedge clk);
    check("brk_busy_held", busy, 1);
    check("brk_fe_count", n_fe - fe0, 1);
    check("brk_no_am", n_am - am0, 0);
    rx_line = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_released", busy, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    idle(20);
    check("brk_desel_no_rv", n_rv - rv0, 0);

    // Reset mid data frame.
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 250);
    rst_n = 1'b0;
    q.delete();
    m_data = 8'h00;
    m_sel = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_pulses", {addr_match, rx_valid, frame_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    rv0 = n_rv;
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    idle(20);
    check("post_rst_no_rv", n_rv - rv0, 0);

    // Recovery: select again and receive.
    send_frame(8'h01, 1'b1, 1'b1, 0);
    send_frame(8'h77, 1'b0, 1'b1, 0);
    idle(20);
    check("recover_rv", n_rv - rv0, 1);
    check("recover_rx_data", rx_data, 8'h77);

    idle(600);
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
